// File: rtl/mcp3008_pkg.sv
// ---------------------------------------------------------------------------
// mcp3008_pkg
// Shared constants and types for the MCP3008 sample receiver.
//   SAMPLE_W        : conversion result width (B9..B0)
//   FIFO_DEPTH      : number of buffered samples
//   FRAME_EDGES     : sclk rising edges in a well-formed frame
//   NULL_EDGE       : rising edge that carries the null bit
//   FIRST_DATA_EDGE : rising edge that carries B9
//   rx_state_t      : receiver FSM states
// ---------------------------------------------------------------------------
package mcp3008_pkg;

  localparam int SAMPLE_W   = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int EDGE_CNT_W = 5;

  // Edge numbers are typed to the counter width so comparisons stay width-clean.
  localparam logic [EDGE_CNT_W-1:0] FRAME_EDGES     = 5'd24;
  localparam logic [EDGE_CNT_W-1:0] NULL_EDGE       = 5'd14;
  localparam logic [EDGE_CNT_W-1:0] FIRST_DATA_EDGE = 5'd15;
  localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX    = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  // True for the edges whose miso value belongs to the sample (B9..B0).
  function automatic logic is_data_edge(input logic [EDGE_CNT_W-1:0] e);
    return (e >= FIRST_DATA_EDGE) && (e <= FRAME_EDGES);
  endfunction

endpackage

// File: rtl/mcp3008_sample_rx_if.sv
// ---------------------------------------------------------------------------
// mcp3008_sample_rx_if
// Valid/ready sample stream leaving the receiver.
//   sample_data  : head sample B9..B0
//   sample_valid : a sample is available
//   sample_ready : consumer accepts the head sample
// Modports: master (receiver side), slave (consumer side).
// ---------------------------------------------------------------------------
interface mcp3008_sample_rx_if;
  import mcp3008_pkg::*;

  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/mcp3008_sample_fifo.sv
// ---------------------------------------------------------------------------
// mcp3008_sample_fifo
// Synchronous FIFO with a combinational head read.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write request and data
//   pop        : read request (ignored when empty)
//   rdata      : head entry, zero while empty
//   full/empty : occupancy flags
//   drop       : push refused because full with no simultaneous pop
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module mcp3008_sample_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the storage array has no reset; only pointers and count do. The head
  // output is masked to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcp3008_sample_rx.sv
// ---------------------------------------------------------------------------
// mcp3008_sample_rx
// Passive receiver for MCP3008 conversion frames. Watches the SPI lines the
// host drives, extracts B9..B0 from rising sclk edges 15..24 of each frame and
// buffers samples in a 4-entry FIFO.
//   clk, rst_n   : system clock, async active-low reset
//   sclk_in      : SPI clock (async)
//   cs_n_in      : SPI chip select, active low (async)
//   miso_in      : MCP3008 DOUT (async)
//   smp          : sample stream (master modport)
//   frame_err    : one-cycle pulse for a malformed frame
//   overflow     : sticky, a valid sample was dropped on a full FIFO
//   overflow_clr : synchronous clear of overflow (a same-cycle drop wins)
// Build option: define MCP3008_RX_NULL_CHECK_EN to reject frames whose null
// bit (edge 14) is 1.
// ---------------------------------------------------------------------------
module mcp3008_sample_rx
  import mcp3008_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk_in,
  input  logic                cs_n_in,
  input  logic                miso_in,
  mcp3008_sample_rx_if.master smp,
  output logic                frame_err,
  output logic                overflow,
  input  logic                overflow_clr
);

  // Synchronizers and edge detection.
  logic [1:0] sclk_sync, cs_sync, miso_sync;
  logic       sclk_q, cs_q;
  logic [1:0] settle;
  logic       armed;
  logic       sclk_s, cs_s, miso_s;
  logic       sclk_rise, cs_fall, cs_rise;

  assign sclk_s = sclk_sync[1];
  assign cs_s   = cs_sync[1];
  assign miso_s = miso_sync[1];

  assign sclk_rise = !sclk_q && sclk_s;
  assign cs_fall   = cs_q && !cs_s;
  assign cs_rise   = !cs_q && cs_s;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (essential in a shift chain).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b11;
      cs_sync   <= 2'b11;
      miso_sync <= 2'b00;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_in};
      cs_sync   <= {cs_sync[0], cs_n_in};
      miso_sync <= {miso_sync[0], miso_in};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
      settle    <= {settle[0], 1'b1};
      // The synchronizers come out of reset reading cs_n high. If reset was
      // released mid-frame that would fake a falling edge, so capture is only
      // armed once the real pin has been seen deasserted.
      if (settle[1] && cs_s) armed <= 1'b1;
    end
  end

  // Frame capture FSM.
  rx_state_t                 state;
  logic [EDGE_CNT_W-1:0]     edge_cnt, edge_nxt;
  logic [SAMPLE_W-1:0]       shift_reg;
  logic                      push_q;
  logic                      frame_ok;
`ifdef MCP3008_RX_NULL_CHECK_EN
  logic                      null_bit;
`endif

  assign edge_nxt = (edge_cnt == EDGE_CNT_MAX) ? edge_cnt : edge_cnt + 1'b1;

`ifdef MCP3008_RX_NULL_CHECK_EN
  assign frame_ok = (edge_cnt == FRAME_EDGES) && !null_bit;
`else
  assign frame_ok = (edge_cnt == FRAME_EDGES);
`endif

  // The verdict is taken on the cs_n rise so the push and frame_err pulse
  // land in the DONE cycle; the FIFO then shows the sample one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      edge_cnt  <= '0;
      shift_reg <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef MCP3008_RX_NULL_CHECK_EN
      null_bit  <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            state     <= SHIFT;
            edge_cnt  <= '0;
            shift_reg <= '0;
`ifdef MCP3008_RX_NULL_CHECK_EN
            null_bit  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= DONE;
            push_q    <= frame_ok;
            frame_err <= !frame_ok;
          end else if (sclk_rise) begin
            edge_cnt <= edge_nxt;
`ifdef MCP3008_RX_NULL_CHECK_EN
            if (edge_nxt == NULL_EDGE) null_bit <= miso_s;
`endif
            if (is_data_edge(edge_nxt)) shift_reg <= {shift_reg[SAMPLE_W-2:0], miso_s};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sample buffer.
  logic fifo_full, fifo_empty, fifo_drop, fifo_pop;

  assign fifo_pop = smp.sample_valid && smp.sample_ready;

  mcp3008_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .wdata (shift_reg),
    .pop   (fifo_pop),
    .rdata (smp.sample_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign smp.sample_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcp3008_sample_rx.sv
// ---------------------------------------------------------------------------
// tb_mcp3008_sample_rx
// Self-checking bench for mcp3008_sample_rx: reset state, latency, a table of
// frame shapes, randomized frames against a queue-based reference model, and
// hand-written overflow / full-FIFO / mid-frame-reset sequences.
// Honours MCP3008_RX_NULL_CHECK_EN when deciding the fate of null=1 frames.
// ---------------------------------------------------------------------------
module tb_mcp3008_sample_rx;
  import mcp3008_pkg::*;

`ifdef MCP3008_RX_NULL_CHECK_EN
  localparam bit NULL_CHECK = 1'b1;
`else
  localparam bit NULL_CHECK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic miso = 1'b0;
  logic overflow_clr = 1'b0;
  logic frame_err;
  logic overflow;

  mcp3008_sample_rx_if smp ();

  mcp3008_sample_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk_in      (sclk),
    .cs_n_in      (cs_n),
    .miso_in      (miso),
    .smp          (smp),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  logic [SAMPLE_W-1:0] got_q[$];   // samples the DUT delivered
  logic [SAMPLE_W-1:0] exp_q[$];   // samples the model says should be delivered
  logic [SAMPLE_W-1:0] mdl_q[$];   // model FIFO contents
  bit                  mdl_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is good only with exactly 24 edges (and a zero
  // null bit when the check is built); the FIFO holds 4 and drops when full.
  function automatic bit frame_ok(input int edges, input bit nullb);
    return (edges == 24) && !(NULL_CHECK && nullb);
  endfunction

  task automatic model_push(input logic [SAMPLE_W-1:0] d);
    if (mdl_q.size() < FIFO_DEPTH) mdl_q.push_back(d);
    else mdl_ovf = 1'b1;
  endtask

  task automatic model_pop();
    if (mdl_q.size() > 0) exp_q.push_back(mdl_q.pop_front());
  endtask

  task automatic compare_delivered(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_data%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Output monitor, sampled on the falling edge.
  logic                hold_prev = 1'b0;
  logic [SAMPLE_W-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", smp.sample_valid, 1);
        check("hold_data", smp.sample_data, data_prev);
      end
      if (smp.sample_valid && smp.sample_ready) got_q.push_back(smp.sample_data);
      if (frame_err) err_cnt++;
      hold_prev = smp.sample_valid && !smp.sample_ready;
      data_prev = smp.sample_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame. Returns just after cs_n rises (1 time unit past a clk
  // rising edge). rst_at > 0 pulses rst_n right after that rising sclk edge.
  task automatic send_frame(input logic [SAMPLE_W-1:0] data, input bit nullb,
                            input int edges, input int rst_at);
    cs_n = 1'b0;
    sclk = 1'b0;
    tick(4);
    for (int k = 1; k <= edges; k++) begin
      if (k == 14)                miso = nullb;
      else if (k >= 15 && k <= 24) miso = data[24-k];
      else                        miso = 1'($urandom_range(0, 1));
      tick(4);
      sclk = 1'b1;
      if (k == rst_at) begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
      end
      tick(4);
      sclk = 1'b0;
    end
    tick(4);
    cs_n = 1'b1;
  endtask

  typedef struct {
    logic [SAMPLE_W-1:0] data;
    bit                  nullb;
    int                  edges;
    bit                  exp_push;
    bit                  exp_err;
  } vec_t;

  vec_t vecs[8];
  bit   rnd_done = 1'b0;

  initial begin
    int err0;
    int n0;
    int exp_errs;

    vecs[0] = '{10'h2A5, 1'b0, 24, 1'b1, 1'b0};
    vecs[1] = '{10'h155, 1'b0, 20, 1'b0, 1'b1};
    vecs[2] = '{10'h3FF, 1'b1, 24, !NULL_CHECK, NULL_CHECK};
    vecs[3] = '{10'h000, 1'b0, 24, 1'b1, 1'b0};
    vecs[4] = '{10'h3FF, 1'b0, 23, 1'b0, 1'b1};
    vecs[5] = '{10'h1C3, 1'b0, 25, 1'b0, 1'b1};
    vecs[6] = '{10'h0AA, 1'b0, 56, 1'b0, 1'b1};  // would alias to 24 without saturation
    vecs[7] = '{10'h200, 1'b0, 0,  1'b0, 1'b1};

    smp.sample_ready = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", smp.sample_valid, 0);
    check("rst_data", smp.sample_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);

    // Basic frame and latency: valid low one cycle after detection, high two after.
    err0 = err_cnt;
    send_frame(10'h2A5, 1'b0, 24, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_n1_valid", smp.sample_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_n2_valid", smp.sample_valid, 1);
    check("lat_data", smp.sample_data, 10'h2A5);
    check("lat_no_err", err_cnt - err0, 0);
    model_push(10'h2A5);
    tick(1);
    smp.sample_ready = 1'b1;
    tick(1);
    smp.sample_ready = 1'b0;
    model_pop();
    tick(2);
    compare_delivered("basic");

    // Table of frame shapes, consumer always ready.
    smp.sample_ready = 1'b1;
    foreach (vecs[i]) begin
      err0 = err_cnt;
      n0 = got_q.size();
      send_frame(vecs[i].data, vecs[i].nullb, vecs[i].edges, 0);
      tick(12);
      check($sformatf("vec%0d_push", i), got_q.size() - n0, vecs[i].exp_push);
      check($sformatf("vec%0d_err", i), err_cnt - err0, vecs[i].exp_err);
      if (vecs[i].exp_push) begin
        model_push(vecs[i].data);
        model_pop();
      end
    end
    compare_delivered("table");

    // Randomized frames with a randomly stalling consumer.
    err0 = err_cnt;
    exp_errs = 0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          logic [SAMPLE_W-1:0] d;
          bit nb;
          int ne;
          d  = SAMPLE_W'($urandom);
          nb = 1'($urandom_range(0, 1));
          ne = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 24;
          if (frame_ok(ne, nb)) begin
            model_push(d);
            model_pop();
          end else begin
            exp_errs++;
          end
          send_frame(d, nb, ne, 0);
          tick(12);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick(1);
          smp.sample_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    smp.sample_ready = 1'b1;
    tick(8);
    check("rand_errs", err_cnt - err0, exp_errs);
    compare_delivered("rand");

    // Overflow: five frames with no consumer.
    smp.sample_ready = 1'b0;
    mdl_ovf = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      send_frame(SAMPLE_W'(d), 1'b0, 24, 0);
      tick(12);
      model_push(SAMPLE_W'(d));
    end
    @(negedge clk);
    check("ovf_set", overflow, mdl_ovf);
    check("ovf_head", smp.sample_data, 10'h001);
    tick(1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    mdl_ovf = 1'b0;
    @(negedge clk);
    check("ovf_clr", overflow, mdl_ovf);
    // Clear coinciding with a fresh drop: the drop wins.
    send_frame(10'h006, 1'b0, 24, 0);
    tick(3);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    model_push(10'h006);
    @(negedge clk);
    check("ovf_clr_vs_drop", overflow, mdl_ovf);
    tick(1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    mdl_ovf = 1'b0;
    @(negedge clk);
    check("ovf_clr2", overflow, mdl_ovf);
    tick(1);
    smp.sample_ready = 1'b1;
    tick(8);
    smp.sample_ready = 1'b0;
    repeat (4) model_pop();
    compare_delivered("ovf");

    // Full FIFO with a pop in the same cycle as the fifth push.
    for (int d = 1; d <= 4; d++) begin
      send_frame(SAMPLE_W'(d), 1'b0, 24, 0);
      tick(12);
      model_push(SAMPLE_W'(d));
    end
    send_frame(10'h005, 1'b0, 24, 0);
    tick(3);
    smp.sample_ready = 1'b1;
    tick(1);
    smp.sample_ready = 1'b0;
    model_pop();
    model_push(10'h005);
    @(negedge clk);
    check("fullpop_ovf", overflow, mdl_ovf);
    check("fullpop_head", smp.sample_data, 10'h002);
    tick(1);
    smp.sample_ready = 1'b1;
    tick(8);
    repeat (4) model_pop();
    compare_delivered("fullpop");

    // Reset in the middle of a frame, then a clean frame.
    err0 = err_cnt;
    send_frame(10'h155, 1'b0, 24, 18);
    tick(12);
    check("midrst_err", err_cnt - err0, 0);
    check("midrst_valid", smp.sample_valid, 0);
    check("midrst_ovf", overflow, 0);
    send_frame(10'h3FF, 1'b0, 24, 0);
    tick(12);
    model_push(10'h3FF);
    model_pop();
    check("midrst_err2", err_cnt - err0, 0);
    compare_delivered("midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mcp3008_sample_rx.md
MCP3008_SAMPLE_RX -- requirements
Module: mcp3008_sample_rx

Interface
REQ-001 The block SHALL have an input `clk`, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-002 The block SHALL have an input `rst_n`, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have an input `sclk_in`, 1 bit: the SPI clock driven to the MCP3008, asynchronous to `clk`.
REQ-004 The block SHALL have an input `cs_n_in`, 1 bit: the SPI chip select, active-low, asynchronous to `clk`.
REQ-005 The block SHALL have an input `miso_in`, 1 bit: the MCP3008 DOUT line, asynchronous to `clk`.
REQ-006 The block SHALL have an output `sample_data`, 10 bits: the FIFO head sample, B9..B0.
REQ-007 The block SHALL have an output `sample_valid`, 1 bit: high when the FIFO is not empty.
REQ-008 The block SHALL have an input `sample_ready`, 1 bit: the consumer accepts the head sample.
REQ-009 The block SHALL have an output `frame_err`, 1 bit: a one-cycle pulse when a frame is malformed.
REQ-010 The block SHALL have an output `overflow`, 1 bit: sticky, set when a sample is dropped.
REQ-011 The block SHALL have an input `overflow_clr`, 1 bit: synchronous clear of `overflow`.

Function
REQ-012 `sclk_in`, `cs_n_in` and `miso_in` SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized values.
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
  - IDLE to SHIFT: on a synchronized `cs_n` falling edge.
  - SHIFT to DONE: on a `cs_n` rising edge.
  - DONE to IDLE: unconditionally after 1 cycle.
REQ-014 On entry to SHIFT, the 5-bit edge counter and the 10-bit shift register SHALL be cleared.
REQ-015 In SHIFT, each `sclk` rising edge SHALL increment the edge counter; the counter SHALL saturate at 31.
REQ-016 Rising edges 15..24 SHALL shift `miso` into the LSB of the shift register, so that B9 is captured first.
REQ-017 Rising edge 14 is the null bit; its value SHALL be latched.
REQ-018 In DONE, a frame SHALL be valid if and only if the edge count equals 24 (and the null check of REQ-027 passes, when enabled).
  - Valid frame: the block SHALL push the shift register into the FIFO.
  - Invalid frame: the block SHALL pulse `frame_err` for 1 cycle and SHALL NOT push.
REQ-019 If `cs_n` rises before edge 24, the frame SHALL be treated as invalid, with no partial sample pushed.
REQ-020 Latency: if the `cs_n` rise is detected in cycle N, `sample_valid` SHALL assert in cycle N+2 when the FIFO was empty.
REQ-021 The FIFO SHALL hold 4 entries and SHALL pop on `sample_valid && sample_ready`.
REQ-022 `sample_data` SHALL remain stable while `sample_valid` is high and `sample_ready` is low.
REQ-023 On a push into a full FIFO with no simultaneous pop, the new sample SHALL be dropped and `overflow` SHALL be set.
REQ-024 On a push with a simultaneous pop when the FIFO is full, both SHALL be accepted and the occupancy SHALL stay at 4.
REQ-025 When `overflow_clr` and a new overflow event occur in the same cycle, `overflow` SHALL remain set.

Reset
REQ-026 While `rst_n` is low, the FSM SHALL be in IDLE and the following SHALL be zero: counters, shift register, FIFO pointers, `sample_data`, `sample_valid`, `frame_err` and `overflow`; the synchronizer flops SHALL be set to 1 for `sclk`/`cs_n` and 0 for `miso`. A reset asserted mid-frame SHALL discard that frame; after release, capture SHALL resume only on a fresh `cs_n` falling edge.

Configuration
REQ-027 With the macro `MCP3008_RX_NULL_CHECK_EN` defined, a null bit of 1 SHALL make the frame invalid (`frame_err` pulse, no push); without the macro, the null bit SHALL be ignored and its latch SHALL not be built.

Structure
REQ-028 The shared package `mcp3008_pkg` SHALL hold the following constants and type:
  - Constants: SAMPLE_W=10, FRAME_EDGES=24, NULL_EDGE=14, FIRST_DATA_EDGE=15, FIFO_DEPTH=4.
  - Type: the typedef enum `rx_state_t` (IDLE, SHIFT, DONE).
REQ-029 The FIFO SHALL be the sub-module `mcp3008_sample_fifo` (parameterized by width and depth, providing full/empty flags).

Verification
REQ-030 The bench SHALL run a 24-edge frame with null=0 and data 10'h2A5 -> `sample_data` = 10'h2A5, `sample_valid` high 2 cycles after the `cs_n` rise, `frame_err` low.
REQ-031 The bench SHALL raise `cs_n` after 20 edges -> one `frame_err` pulse, `sample_valid` stays low.
REQ-032 The bench SHALL send a frame with null=1 -> with the macro: `frame_err` pulse and no push; without the macro: sample pushed.
REQ-033 The bench SHALL send 5 frames (10'h001..10'h005) with `sample_ready`=0 -> FIFO holds 10'h001..10'h004, `overflow`=1; `overflow_clr` then returns it to 0.
REQ-034 The bench SHALL hold the FIFO full with `sample_ready`=1 during the 5th push -> 10'h001 popped, 10'h005 stored, `overflow` stays 0.
REQ-035 The bench SHALL assert `rst_n` at edge 18 of a frame, then run a complete frame 10'h3FF -> only 10'h3FF is delivered.
